// File: rtl/tqvp_vga_capture.sv
// VGA-style 2-bpp stream receiver: line targeting, 64-sample capture buffer, capture-done interrupt.
// Optional line-period / frame-height measurement is enabled with `define VGA_CAPTURE_MEASURE_EN.
`timescale 1ns/1ps

module tqvp_vga_capture (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    typedef enum logic [1:0] {IDLE, WAIT_LINE, CAPTURE, DONE_ST} state_t;

    state_t       state_q, state_d;
    logic         hs_q, hs_d, hs_prev_q, hs_prev_d;
    logic         vs_q, vs_d, vs_prev_q, vs_prev_d;
    logic [1:0]   pix_q, pix_d;
    logic         hpol_q, hpol_d, vpol_q, vpol_d, cont_q, cont_d;
    logic         done_q, done_d, short_q, short_d, irq_q, irq_d;
    logic [10:0]  line_q, line_d, line_cnt_q, line_cnt_d;
    logic [11:0]  xstart_q, xstart_d;
    logic [3:0]   step_q, step_d;
    logic [12:0]  x_q, x_d, pos_q, pos_d;
    logic [5:0]   k_q, k_d;
    logic [127:0] buf_q, buf_d;

    logic         hs_act, hs_act_prev, vs_act, vs_act_prev;
    logic         hs_assert, hs_deassert, vs_assert;
    logic         wr_en, rd_en, start;
    logic [12:0]  cur_x, cur_pos;
    logic [5:0]   cur_k;
    logic [31:0]  meas_word;
    logic         unused_bits;

    assign uo_out         = 8'h00;
    assign data_ready     = 1'b1;
    assign user_interrupt = irq_q;
    assign unused_bits    = ^{ui_in[7:4], data_in[31:20], data_in[15:12]};

    // Polarity bit equals the level that counts as active.
    assign hs_act      = (hs_q == hpol_q);
    assign hs_act_prev = (hs_prev_q == hpol_q);
    assign vs_act      = (vs_q == vpol_q);
    assign vs_act_prev = (vs_prev_q == vpol_q);
    assign hs_assert   = hs_act & ~hs_act_prev;
    assign hs_deassert = ~hs_act & hs_act_prev;
    assign vs_assert   = vs_act & ~vs_act_prev;

    assign wr_en = (data_write_n != 2'b11);
    assign rd_en = (data_read_n != 2'b11);

    // The detect cycle of the start edge is itself capture cycle x=0.
    assign start   = (state_q == WAIT_LINE) && hs_deassert && (line_cnt_q == line_q);
    assign cur_x   = start ? 13'd0 : x_q;
    assign cur_k   = start ? 6'd0 : k_q;
    assign cur_pos = start ? {1'b0, xstart_q} : pos_q;

    always_comb begin
        state_d    = state_q;
        hs_d       = ui_in[0];
        vs_d       = ui_in[1];
        pix_d      = ui_in[3:2];
        hs_prev_d  = hs_q;
        vs_prev_d  = vs_q;
        hpol_d     = hpol_q;
        vpol_d     = vpol_q;
        cont_d     = cont_q;
        done_d     = done_q;
        short_d    = short_q;
        irq_d      = irq_q;
        line_d     = line_q;
        xstart_d   = xstart_q;
        step_d     = step_q;
        line_cnt_d = line_cnt_q;
        x_d        = x_q;
        pos_d      = pos_q;
        k_d        = k_q;
        buf_d      = buf_q;

        if (vs_assert)
            line_cnt_d = 11'd0;
        else if (hs_assert && (line_cnt_q != 11'h7FF))
            line_cnt_d = line_cnt_q + 11'd1;

        if (rd_en && (address == 6'h00)) begin
            done_d = 1'b0;
            irq_d  = 1'b0;
        end

        if (start || (state_q == CAPTURE)) begin
            if ((state_q == CAPTURE) && vs_assert) begin
                state_d = WAIT_LINE;
            end else if ((state_q == CAPTURE) && hs_assert) begin
                short_d = 1'b1;
                state_d = DONE_ST;
            end else begin
                state_d = CAPTURE;
                x_d     = (cur_x == 13'h1FFF) ? cur_x : cur_x + 13'd1;
                k_d     = cur_k;
                pos_d   = cur_pos;
                if (cur_x == cur_pos) begin
                    buf_d[{cur_k, 1'b0} +: 2] = pix_q;
                    k_d   = cur_k + 6'd1;
                    pos_d = cur_pos + {9'd0, step_q} + 13'd1;
                    if (cur_k == 6'd63)
                        state_d = DONE_ST;
                end
            end
        end else if (state_q == DONE_ST) begin
            done_d  = 1'b1;
            irq_d   = 1'b1;
            state_d = cont_q ? WAIT_LINE : IDLE;
        end

        // CPU writes override any FSM transition in the same cycle.
        if (wr_en) begin
            case (address)
                6'h00: begin
                    hpol_d = data_in[1];
                    vpol_d = data_in[2];
                    cont_d = data_in[3];
                    if (data_in[0]) begin
                        state_d = WAIT_LINE;
                        short_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                6'h04: line_d = data_in[10:0];
                6'h08: begin
                    xstart_d = data_in[11:0];
                    step_d   = data_in[19:16];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            pix_q      <= 2'd0;
            hs_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            hpol_q     <= 1'b0;
            vpol_q     <= 1'b0;
            cont_q     <= 1'b0;
            done_q     <= 1'b0;
            short_q    <= 1'b0;
            irq_q      <= 1'b0;
            line_q     <= 11'd0;
            xstart_q   <= 12'd0;
            step_q     <= 4'd0;
            line_cnt_q <= 11'd0;
            x_q        <= 13'd0;
            pos_q      <= 13'd0;
            k_q        <= 6'd0;
            buf_q      <= 128'd0;
        end else begin
            state_q    <= state_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            pix_q      <= pix_d;
            hs_prev_q  <= hs_prev_d;
            vs_prev_q  <= vs_prev_d;
            hpol_q     <= hpol_d;
            vpol_q     <= vpol_d;
            cont_q     <= cont_d;
            done_q     <= done_d;
            short_q    <= short_d;
            irq_q      <= irq_d;
            line_q     <= line_d;
            xstart_q   <= xstart_d;
            step_q     <= step_d;
            line_cnt_q <= line_cnt_d;
            x_q        <= x_d;
            pos_q      <= pos_d;
            k_q        <= k_d;
            buf_q      <= buf_d;
        end
    end

`ifdef VGA_CAPTURE_MEASURE_EN
    logic [11:0] hp_cnt_q, hp_cnt_d, hperiod_q, hperiod_d;
    logic [10:0] fl_cnt_q, fl_cnt_d, frame_lines_q, frame_lines_d;
    logic        vs_seen_q, vs_seen_d;

    // The first vsync edge after reset only opens a frame; nothing complete to report yet.
    always_comb begin
        hp_cnt_d      = (hp_cnt_q == 12'hFFF) ? hp_cnt_q : hp_cnt_q + 12'd1;
        hperiod_d     = hperiod_q;
        fl_cnt_d      = fl_cnt_q;
        frame_lines_d = frame_lines_q;
        vs_seen_d     = vs_seen_q;
        if (hs_assert) begin
            hp_cnt_d  = 12'd1;
            hperiod_d = hp_cnt_q;
        end
        if (vs_assert) begin
            if (vs_seen_q)
                frame_lines_d = fl_cnt_q;
            vs_seen_d = 1'b1;
            fl_cnt_d  = hs_assert ? 11'd1 : 11'd0;
        end else if (hs_assert && (fl_cnt_q != 11'h7FF)) begin
            fl_cnt_d = fl_cnt_q + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hp_cnt_q      <= 12'd0;
            hperiod_q     <= 12'd0;
            fl_cnt_q      <= 11'd0;
            frame_lines_q <= 11'd0;
            vs_seen_q     <= 1'b0;
        end else begin
            hp_cnt_q      <= hp_cnt_d;
            hperiod_q     <= hperiod_d;
            fl_cnt_q      <= fl_cnt_d;
            frame_lines_q <= frame_lines_d;
            vs_seen_q     <= vs_seen_d;
        end
    end

    assign meas_word = {5'd0, frame_lines_q, 4'd0, hperiod_q};
`else
    assign meas_word = 32'd0;
`endif

    always_comb begin
        data_out = 32'd0;
        case (address)
            6'h00: data_out = {26'd0, short_q, done_q, cont_q, vpol_q, hpol_q, (state_q != IDLE)};
            6'h04: data_out = {21'd0, line_q};
            6'h08: data_out = {12'd0, step_q, 4'd0, xstart_q};
            6'h0C: data_out = meas_word;
            6'h10: data_out = buf_q[31:0];
            6'h14: data_out = buf_q[63:32];
            6'h18: data_out = buf_q[95:64];
            6'h1C: data_out = buf_q[127:96];
            default: data_out = 32'd0;
        endcase
    end

endmodule
